// File: rtl/multicycle_core.sv
// Multicycle LEGv8 core: one FSM sequences fetch/decode/exec/mem/writeback over a
// shared ALU, with req/valid handshakes to instruction and data memories.
module multicycle_core #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              resetl,
  input  logic [ADDR_W-1:0] startpc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              imem_valid,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_valid,
  output logic [ADDR_W-1:0] currentpc,
  output logic [DATA_W-1:0] wb_data,
  output logic              retire,
  output logic              illegal,
  output logic [CNT_W-1:0]  retire_cnt,
  output logic [CNT_W-1:0]  cycle_cnt
);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;
  typedef enum logic [3:0] {I_ADD, I_SUB, I_AND, I_ORR, I_LDUR, I_STUR,
                            I_CBZ, I_B, I_MOVZ, I_ILL} instr_t;

  state_t            state, state_nxt;
  instr_t            kind;
  logic [31:0]       ir;
  logic [DATA_W-1:0] regs [32];
  logic [DATA_W-1:0] a_reg, b_reg, imm_reg, res_reg;
  logic [DATA_W-1:0] rd_a, rd_b, sext_val, movz_val, alu_y;
  logic [ADDR_W-1:0] pc, pc_nxt, pc_seq, pc_br;
  logic [4:0]        rs2;
  logic              retire_nxt;

  // Opcode decode; MOVZ with hw>1 has no meaning on a 32-bit datapath.
  always_comb begin
    kind = I_ILL;
    if (ir[31:21] == 11'b10001011000)      kind = I_ADD;
    else if (ir[31:21] == 11'b11001011000) kind = I_SUB;
    else if (ir[31:21] == 11'b10001010000) kind = I_AND;
    else if (ir[31:21] == 11'b10101010000) kind = I_ORR;
    else if (ir[31:21] == 11'b11111000010) kind = I_LDUR;
    else if (ir[31:21] == 11'b11111000000) kind = I_STUR;
    else if (ir[31:24] == 8'b10110100)     kind = I_CBZ;
    else if (ir[31:26] == 6'b000101)       kind = I_B;
    else if (ir[31:23] == 9'b110100101 && !(DATA_W == 32 && ir[22])) kind = I_MOVZ;
  end

  assign rs2  = (kind == I_STUR || kind == I_CBZ) ? ir[4:0] : ir[20:16];
  assign rd_a = (ir[9:5] == 5'd31) ? '0 : regs[ir[9:5]];
  assign rd_b = (rs2 == 5'd31) ? '0 : regs[rs2];

  always_comb begin
    case (kind)
      I_LDUR, I_STUR: sext_val = {{(DATA_W-9){ir[20]}}, ir[20:12]};
      I_CBZ:          sext_val = {{(DATA_W-19){ir[23]}}, ir[23:5]};
      I_B:            sext_val = {{(DATA_W-26){ir[25]}}, ir[25:0]};
      default:        sext_val = '0;
    endcase
  end

  assign movz_val = {{(DATA_W-16){1'b0}}, ir[20:5]} << {ir[22:21], 4'b0000};

  always_comb begin
    case (kind)
      I_ADD:          alu_y = a_reg + b_reg;
      I_SUB:          alu_y = a_reg - b_reg;
      I_AND:          alu_y = a_reg & b_reg;
      I_ORR:          alu_y = a_reg | b_reg;
      I_LDUR, I_STUR: alu_y = a_reg + imm_reg;
      I_MOVZ:         alu_y = movz_val;
      default:        alu_y = '0;
    endcase
  end

  assign pc_seq = pc + ADDR_W'(4);
  assign pc_br  = pc + (imm_reg[ADDR_W-1:0] << 2);

  always_ff @(posedge clk) begin
    if (resetl) state <= S_FETCH;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    retire_nxt = 1'b0;
    case (state)
      S_FETCH:  if (imem_valid) state_nxt = S_DECODE;
      S_DECODE: state_nxt = (kind == I_ILL) ? S_HALT : S_EXEC;
      S_EXEC: begin
        case (kind)
          I_LDUR, I_STUR: state_nxt = S_MEM;
          I_CBZ: begin
            pc_nxt     = (b_reg == '0) ? pc_br : pc_seq;
            retire_nxt = 1'b1;
            state_nxt  = S_FETCH;
          end
          I_B: begin
            pc_nxt     = pc_br;
            retire_nxt = 1'b1;
            state_nxt  = S_FETCH;
          end
          default: state_nxt = S_WB;
        endcase
      end
      S_MEM: begin
        if (dmem_valid) begin
          if (kind == I_STUR) begin
            pc_nxt     = pc_seq;
            retire_nxt = 1'b1;
            state_nxt  = S_FETCH;
          end else begin
            state_nxt  = S_WB;
          end
        end
      end
      S_WB: begin
        pc_nxt     = pc_seq;
        retire_nxt = 1'b1;
        state_nxt  = S_FETCH;
      end
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_FETCH;
    endcase
  end

  // Requests are gated by reset so an outstanding handshake dies immediately.
  assign imem_req   = (state == S_FETCH) && !resetl;
  assign dmem_req   = (state == S_MEM) && !resetl;
  assign dmem_we    = dmem_req && (kind == I_STUR);
  assign imem_addr  = pc;
  assign currentpc  = pc;
  assign dmem_addr  = res_reg[ADDR_W-1:0];
  assign dmem_wdata = b_reg;

  always_ff @(posedge clk) begin
    if (resetl) begin
      pc         <= startpc;
      wb_data    <= '0;
      retire     <= 1'b0;
      illegal    <= 1'b0;
      retire_cnt <= '0;
      cycle_cnt  <= '0;
    end else begin
      pc        <= pc_nxt;
      retire    <= retire_nxt;
      cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (retire_nxt) retire_cnt <= retire_cnt + CNT_W'(1);
      case (state)
        S_FETCH:  if (imem_valid) ir <= imem_rdata;
        S_DECODE: begin
          a_reg   <= rd_a;
          b_reg   <= rd_b;
          imm_reg <= sext_val;
          if (kind == I_ILL) illegal <= 1'b1;
        end
        S_EXEC:   res_reg <= alu_y;
        S_MEM:    if (dmem_valid && kind == I_LDUR) res_reg <= dmem_rdata;
        S_WB:     wb_data <= res_reg;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetl && state == S_WB && ir[4:0] != 5'd31) regs[ir[4:0]] <= res_reg;
  end

endmodule

// File: tb/tb_multicycle_core.sv
// Bench for multicycle_core: directed and random LEGv8 programs checked against an
// instruction-level reference model with wait-state memories.
module tb_multicycle_core;
  localparam int DW = 64;
  localparam int AW = 64;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          resetl;
  logic [AW-1:0] startpc;
  logic          imem_req, imem_valid, dmem_req, dmem_we, dmem_valid;
  logic [AW-1:0] imem_addr, dmem_addr, currentpc;
  logic [31:0]   imem_rdata;
  logic [DW-1:0] dmem_wdata, dmem_rdata, wb_data;
  logic          retire, illegal;
  logic [CW-1:0] retire_cnt, cycle_cnt;

  multicycle_core #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .resetl(resetl), .startpc(startpc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_valid(imem_valid),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_valid(dmem_valid), .currentpc(currentpc), .wb_data(wb_data),
    .retire(retire), .illegal(illegal), .retire_cnt(retire_cnt), .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  // Memories: instruction words alias on address bits [9:2], data on bits [7:3].
  logic [31:0] prog [256];
  logic [63:0] dmem_arr [32];
  logic        dmem_clr;
  int          ilat, dlat, icnt, dcnt;

  assign imem_rdata = prog[imem_addr[9:2]];
  assign dmem_rdata = dmem_arr[dmem_addr[7:3]];
  assign imem_valid = imem_req && (icnt >= ilat);
  assign dmem_valid = dmem_req && (dcnt >= dlat);

  always @(posedge clk) begin
    if (resetl || !imem_req || imem_valid) icnt <= 0; else icnt <= icnt + 1;
    if (resetl || !dmem_req || dmem_valid) dcnt <= 0; else dcnt <= dcnt + 1;
  end

  always @(posedge clk) begin
    if (dmem_clr) for (int i = 0; i < 32; i++) dmem_arr[i] <= '0;
    else if (!resetl && dmem_req && dmem_valid && dmem_we) dmem_arr[dmem_addr[7:3]] <= dmem_wdata;
  end

  int n_chk = 0, n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Encoders
  function automatic logic [31:0] enc_r(input logic [10:0] op, input logic [4:0] rm, rn, rd);
    return {op, rm, 6'd0, rn, rd};
  endfunction
  function automatic logic [31:0] enc_d(input logic [10:0] op, input logic [8:0] imm, input logic [4:0] rn, rt);
    return {op, imm, 2'b00, rn, rt};
  endfunction
  function automatic logic [31:0] enc_cbz(input logic [18:0] imm, input logic [4:0] rt);
    return {8'b10110100, imm, rt};
  endfunction
  function automatic logic [31:0] enc_b(input logic [25:0] imm);
    return {6'b000101, imm};
  endfunction
  function automatic logic [31:0] enc_movz(input logic [1:0] hw, input logic [15:0] imm, input logic [4:0] rd);
    return {9'b110100101, hw, imm, rd};
  endfunction

  localparam logic [10:0] OP_ADD = 11'b10001011000, OP_SUB = 11'b11001011000,
                          OP_AND = 11'b10001010000, OP_ORR = 11'b10101010000,
                          OP_LDUR = 11'b11111000010, OP_STUR = 11'b11111000000;

  // Architectural reference state
  logic [63:0] mregs [32];
  logic [63:0] mdmem [32];
  logic [63:0] mpc;
  int          mret, mcyc;

  function automatic logic [63:0] xr(input logic [4:0] r);
    return (r == 5'd31) ? 64'd0 : mregs[r];
  endfunction

  function automatic bit is_legal(input logic [31:0] w);
    casez (w[31:21])
      OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_LDUR, OP_STUR,
      11'b10110100???, 11'b000101?????, 11'b110100101??: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_exec(input logic [31:0] w, output bit wb_en, output logic [63:0] wb_val,
                            output int lat);
    logic [63:0] a, b, ea;
    longint off;
    a = xr(w[9:5]);
    b = xr(w[20:16]);
    wb_en = 1'b0; wb_val = '0; lat = ilat;
    mpc = mpc + 64'd4;
    casez (w[31:21])
      OP_ADD: begin wb_en = 1; wb_val = a + b; lat += 4; end
      OP_SUB: begin wb_en = 1; wb_val = a - b; lat += 4; end
      OP_AND: begin wb_en = 1; wb_val = a & b; lat += 4; end
      OP_ORR: begin wb_en = 1; wb_val = a | b; lat += 4; end
      OP_LDUR: begin
        off = $signed(w[20:12]); ea = a + off;
        wb_en = 1; wb_val = mdmem[ea[7:3]]; lat += 5 + dlat;
      end
      OP_STUR: begin
        off = $signed(w[20:12]); ea = a + off;
        mdmem[ea[7:3]] = xr(w[4:0]); lat += 4 + dlat;
      end
      11'b10110100???: begin
        off = $signed(w[23:5]);
        if (xr(w[4:0]) == 64'd0) mpc = mpc - 64'd4 + off * 4;
        lat += 3;
      end
      11'b000101?????: begin
        off = $signed(w[25:0]);
        mpc = mpc - 64'd4 + off * 4;
        lat += 3;
      end
      11'b110100101??: begin wb_en = 1; wb_val = 64'(w[20:5]) << (16 * w[22:21]); lat += 4; end
      default: ;
    endcase
    if (wb_en && w[4:0] != 5'd31) mregs[w[4:0]] = wb_val;
  endtask

  task automatic do_reset(input logic [63:0] sp);
    @(negedge clk);
    resetl = 1'b1; startpc = sp;
    @(negedge clk);
    check("rst_pc", currentpc, sp);
    check("rst_cycle_cnt", cycle_cnt, 0);
    check("rst_retire_cnt", retire_cnt, 0);
    check("rst_illegal", illegal, 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_retire", retire, 0);
    check("rst_dmem_req", dmem_req, 0);
    resetl = 1'b0;
    #1;
    check("rst_imem_req", imem_req, 1);
    check("rst_imem_addr", imem_addr, sp);
    mpc = sp; mret = 0; mcyc = 0;
  endtask

  task automatic run_prog(input int max_cyc);
    int n, since, lat;
    bit done, in_d, wb_en;
    logic [31:0] w;
    logic [63:0] wb_val, ea, cap_addr, cap_wd;
    logic        cap_we;
    longint      off;
    n = 0; since = 0; done = 0; in_d = 0;
    while (!done) begin
      @(negedge clk);
      n++; since++;
      w = prog[mpc[9:2]];
      if (n > max_cyc) begin
        check("timeout", n, max_cyc);
        done = 1;
      end else begin
        if (dmem_req && !in_d) begin
          off = $signed(w[20:12]);
          ea = xr(w[9:5]) + off;
          check("dmem_addr", dmem_addr, ea);
          check("dmem_we", dmem_we, w[31:21] == OP_STUR);
          if (w[31:21] == OP_STUR) check("dmem_wdata", dmem_wdata, xr(w[4:0]));
          cap_addr = dmem_addr; cap_wd = dmem_wdata; cap_we = dmem_we; in_d = 1;
        end else if (dmem_req) begin
          check("hold_addr", dmem_addr, cap_addr);
          check("hold_wdata", dmem_wdata, cap_wd);
          check("hold_we", dmem_we, cap_we);
        end
        if (!dmem_req) in_d = 0;
        if (retire) begin
          if (!is_legal(w)) begin
            check("retire_on_illegal", retire, 0);
            done = 1;
          end else begin
            model_exec(w, wb_en, wb_val, lat);
            mret++; mcyc += lat;
            check("retire_pc", currentpc, mpc);
            check("fetch_addr", imem_addr, mpc);
            check("retire_cnt", retire_cnt, mret);
            check("retire_cycle", cycle_cnt, mcyc);
            if (wb_en) check("wb_data", wb_data, wb_val);
            since = 0;
          end
        end else if (!is_legal(w)) begin
          if (since == ilat + 1) begin
            check("illegal_early", illegal, 0);
          end else if (since == ilat + 2) begin
            check("illegal", illegal, 1);
            check("halt_cycle", cycle_cnt, mcyc + ilat + 2);
            for (int k = 1; k <= 6; k++) begin
              @(negedge clk);
              check("halt_retire", retire, 0);
              check("halt_retire_cnt", retire_cnt, mret);
              check("halt_pc", currentpc, mpc);
              check("halt_req", {imem_req, dmem_req}, 0);
              check("halt_cycle_cnt", cycle_cnt, mcyc + ilat + 2 + k);
            end
            done = 1;
          end
        end
      end
    end
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) prog[i] = 32'hFFFF_FFFF;
  endtask

  task automatic load_random(input int s, input int len);
    logic [10:0] op;
    clear_prog();
    for (int i = 0; i < len; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 9: begin
          case ($urandom_range(0, 3))
            0: op = OP_ADD; 1: op = OP_SUB; 2: op = OP_AND; default: op = OP_ORR;
          endcase
          prog[s+i] = enc_r(op, 5'($urandom), 5'($urandom), 5'($urandom));
        end
        4: prog[s+i] = enc_movz(2'($urandom), 16'($urandom), 5'($urandom));
        5: prog[s+i] = enc_d(OP_STUR, 9'(8 * $urandom_range(0, 31)), 5'd31, 5'($urandom));
        6: prog[s+i] = enc_d(OP_LDUR, 9'(8 * $urandom_range(0, 31)), 5'd31, 5'($urandom));
        7: prog[s+i] = enc_cbz(19'($urandom_range(1, 3)), ($urandom_range(0, 2) == 0) ? 5'd31 : 5'($urandom));
        default: prog[s+i] = enc_b(26'($urandom_range(1, 2)));
      endcase
    end
  endtask

  initial begin
    logic [63:0] old;
    int n, s;
    resetl = 1'b1; startpc = '0; ilat = 0; dlat = 0; dmem_clr = 1'b1;
    for (int i = 0; i < 32; i++) begin mregs[i] = '0; mdmem[i] = '0; end
    clear_prog();
    repeat (2) @(negedge clk);
    dmem_clr = 1'b0;

    // Give every register a known value
    for (int i = 0; i < 31; i++) prog[64+i] = enc_movz(2'd0, 16'((i + 1) * 3), 5'(i));
    do_reset(64'h100);
    run_prog(400);

    clear_prog();
    prog[64] = enc_movz(2'd0, 16'd5, 5'd1);
    prog[65] = enc_r(OP_ADD, 5'd1, 5'd1, 5'd2);
    do_reset(64'h100);
    run_prog(100);
    check("t2_wb", wb_data, 10);
    check("t2_retired", retire_cnt, 2);

    clear_prog();
    dlat = 3;
    prog[64] = enc_d(OP_STUR, 9'd8, 5'd31, 5'd2);
    prog[65] = enc_d(OP_LDUR, 9'd8, 5'd31, 5'd3);
    prog[66] = enc_d(OP_STUR, 9'd16, 5'd31, 5'd3);
    do_reset(64'h100);
    run_prog(100);
    check("t3_wb", wb_data, 10);
    check("t3_mem", dmem_arr[2], 10);
    dlat = 0;

    clear_prog();
    prog[64] = enc_cbz(19'd4, 5'd31);
    prog[68] = enc_cbz(19'd4, 5'd1);
    do_reset(64'h100);
    run_prog(100);
    check("t4_pc", currentpc, 64'h114);

    clear_prog();
    do_reset(64'h100);
    run_prog(50);

    // Reset lands while a store is stalled in the data handshake
    clear_prog();
    prog[64]  = enc_d(OP_STUR, 9'd40, 5'd31, 5'd5);
    prog[128] = enc_movz(2'd0, 16'd1, 5'd7);
    dlat = 10;
    do_reset(64'h100);
    n = 0;
    while (!dmem_req && n < 20) begin @(negedge clk); n++; end
    check("t6_in_mem", dmem_req, 1);
    @(negedge clk);
    old = dmem_arr[5];
    do_reset(64'h200);
    dlat = 0;
    run_prog(100);
    check("t6_no_store", dmem_arr[5], old);

    // PC wraps through zero
    clear_prog();
    prog[254] = enc_b(26'd3);
    prog[1]   = enc_movz(2'd1, 16'h77, 5'd9);
    do_reset(64'hFFFF_FFFF_FFFF_FFF8);
    run_prog(100);
    check("wrap_wb", wb_data, 64'h77_0000);

    for (int t = 0; t < 8; t++) begin
      s = $urandom_range(16, 200);
      load_random(s, 14);
      ilat = $urandom_range(0, 2);
      dlat = $urandom_range(0, 3);
      do_reset(64'(s * 4));
      run_prog(600);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
